// File: rtl/csm_pkg.sv
// Shared types for the CSM storage-array arbiter.
package csm_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_LOCKWAIT = 2'b01,
    ERR_REVOKED  = 2'b10,
    ERR_BADREL   = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RDWAIT = 2'b10,
    RESP   = 2'b11
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Status reported with an ack; a revoked lock outranks a bad release,
  // which outranks having waited on the other port's lock.
  function automatic err_t encode_err(input logic revoked, input logic badrel,
                                      input logic lockwait);
    if (revoked)       return ERR_REVOKED;
    else if (badrel)   return ERR_BADREL;
    else if (lockwait) return ERR_LOCKWAIT;
    else               return ERR_OK;
  endfunction

endpackage

// File: rtl/csm_port_capture.sv
// Per-port front end: splits the multiplexed AD bus into address and write
// data, holds the pending request until the arbiter acks it, and latches
// release pulses until the arbiter gets round to applying them.
module csm_port_capture
  import csm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_ad,
  input  logic              rw,
  input  logic              enable,
  input  logic              hold,
  input  logic              rel,
  input  logic              done,
  input  logic              rel_consume,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              rw_q,
  output logic              hold_q,
  output logic              pending,
  output logic              capturing,
  output logic              rel_pend
);

  logic enable_d;
  logic start;

  // A rising edge only opens a transaction when nothing is in flight.
  assign start = enable & ~enable_d & ~pending & ~capturing;

  // Address phase, write-data phase, pending flag and release latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_d  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rw_q      <= 1'b0;
      hold_q    <= 1'b0;
      pending   <= 1'b0;
      capturing <= 1'b0;
      rel_pend  <= 1'b0;
    end else begin
      enable_d <= enable;
      // done is applied first so a request opened in the ack cycle of an
      // idle-port BADREL response is not lost.
      if (done) pending <= 1'b0;
      if (start) begin
        addr   <= in_ad;
        rw_q   <= rw;
        hold_q <= hold;
        if (rw) pending   <= 1'b1;
        else    capturing <= 1'b1;
      end
      if (capturing) begin
        wdata     <= in_ad;
        capturing <= 1'b0;
        pending   <= 1'b1;
      end
      // A fresh pulse survives a consume in the same cycle.
      rel_pend <= rel | (rel_pend & ~rel_consume);
    end
  end

endmodule

// File: rtl/csm_arbiter.sv
// Round-robin arbiter sequencing the single-ported CSM array between
// requester ports A and B, with a hold/release lock and starvation timeout.
//
// state  | meaning
// IDLE   | apply latched releases, pick a port (or a BADREL-only ack)
// ACCESS | drive the array strobe for the granted port, take the lock
// RDWAIT | register the array read data
// RESP   | ack the granted port with its status, clear its request
module csm_arbiter
  import csm_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 16,
  parameter bit RR_INIT      = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] A_in_AD,
  input  logic              A_rw,
  input  logic              A_enable,
  input  logic              A_hold,
  input  logic              A_release,
  output logic              A_ack,
  output logic [DATA_W-1:0] A_out_data,
  output logic [1:0]        A_err,
  input  logic [DATA_W-1:0] B_in_AD,
  input  logic              B_rw,
  input  logic              B_enable,
  input  logic              B_hold,
  input  logic              B_release,
  output logic              B_ack,
  output logic [DATA_W-1:0] B_out_data,
  output logic [1:0]        B_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(HOLD_TIMEOUT - 1);

  logic [DATA_W-1:0] addr_q  [2];
  logic [DATA_W-1:0] wdata_q [2];
  logic [1:0] pend, cap, rw_q, hold_q, rel_pend;
  logic [1:0] done, rel_consume;

  state_t state, state_nxt;
  port_t  grant, grant_nxt;
  port_t  rr_ptr, rr_nxt;
  port_t  lock_owner;
  logic   lock_valid;
  logic [CNT_W-1:0] tmr;
  logic [1:0] revoked, badrel, lockwait;
  logic [DATA_W-1:0] rdata_q;
  logic resp_rd;

  logic own_a, own_b, lock_rel, lock_free, tmr_run, tmo_hit;
  logic [1:0] badrel_set, badrel_eff, idle_ack, elig, lockwait_set, revoke_set;
  logic acc_en, rsp_en;
  err_t resp_err;

  csm_port_capture #(.DATA_W(DATA_W)) u_cap_a (
    .clk(clk), .reset_n(reset_n), .in_ad(A_in_AD), .rw(A_rw), .enable(A_enable),
    .hold(A_hold), .rel(A_release), .done(done[0]), .rel_consume(rel_consume[0]),
    .addr(addr_q[0]), .wdata(wdata_q[0]), .rw_q(rw_q[0]), .hold_q(hold_q[0]),
    .pending(pend[0]), .capturing(cap[0]), .rel_pend(rel_pend[0])
  );

  csm_port_capture #(.DATA_W(DATA_W)) u_cap_b (
    .clk(clk), .reset_n(reset_n), .in_ad(B_in_AD), .rw(B_rw), .enable(B_enable),
    .hold(B_hold), .rel(B_release), .done(done[1]), .rel_consume(rel_consume[1]),
    .addr(addr_q[1]), .wdata(wdata_q[1]), .rw_q(rw_q[1]), .hold_q(hold_q[1]),
    .pending(pend[1]), .capturing(cap[1]), .rel_pend(rel_pend[1])
  );

  assign own_a = lock_valid && (lock_owner == PORT_A);
  assign own_b = lock_valid && (lock_owner == PORT_B);

  // Releases are applied before arbitration, so a dropped lock is free for
  // the grant decided in the same IDLE cycle.
  always_comb begin
    rel_consume = 2'b00;
    badrel_set  = 2'b00;
    lock_rel    = 1'b0;
    if (state == IDLE) begin
      rel_consume   = rel_pend;
      lock_rel      = (rel_pend[0] & own_a) | (rel_pend[1] & own_b);
      badrel_set[0] = rel_pend[0] & ~own_a;
      badrel_set[1] = rel_pend[1] & ~own_b;
    end
    lock_free  = ~lock_valid | lock_rel;
    elig[0]    = pend[0] & (lock_free | own_a);
    elig[1]    = pend[1] & (lock_free | own_b);
    badrel_eff = badrel | badrel_set;
    idle_ack   = badrel_eff & ~pend & ~cap;
  end

  // Next state, grant and round-robin pointer; the pointer only moves when
  // both ports actually contended.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (idle_ack[0]) begin
          state_nxt = RESP;
          grant_nxt = PORT_A;
        end else if (idle_ack[1]) begin
          state_nxt = RESP;
          grant_nxt = PORT_B;
        end else if (elig[0] && elig[1]) begin
          state_nxt = ACCESS;
          grant_nxt = rr_ptr;
          rr_nxt    = (rr_ptr == PORT_A) ? PORT_B : PORT_A;
        end else if (elig[0]) begin
          state_nxt = ACCESS;
          grant_nxt = PORT_A;
        end else if (elig[1]) begin
          state_nxt = ACCESS;
          grant_nxt = PORT_B;
        end
      end
      ACCESS:  state_nxt = rw_q[grant] ? RDWAIT : RESP;
      RDWAIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      grant  <= PORT_A;
      rr_ptr <= port_t'(RR_INIT);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Starvation timer: loaded while idle, counts down while the owner sits
  // idle on the lock and the other port waits.
  assign tmr_run = (own_a & pend[1] & ~pend[0]) | (own_b & pend[0] & ~pend[1]);
  assign tmo_hit = tmr_run && (tmr == '0);

  always_ff @(posedge clk) begin
    if (!reset_n)                tmr <= TMR_LOAD;
    else if (!tmr_run || tmo_hit) tmr <= TMR_LOAD;
    else                         tmr <= tmr - 1'b1;
  end

  // Lock ownership: taken at ACCESS with hold, dropped by release or timeout.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_valid <= 1'b0;
      lock_owner <= PORT_A;
    end else if (tmo_hit || lock_rel) begin
      lock_valid <= 1'b0;
    end else if (state == ACCESS && hold_q[grant] && !lock_valid) begin
      lock_valid <= 1'b1;
      lock_owner <= grant;
    end
  end

  assign lockwait_set = {pend[1] & own_a, pend[0] & own_b};
  assign revoke_set   = {tmo_hit & own_b, tmo_hit & own_a};
  assign done[0]      = (state == RESP) && (grant == PORT_A);
  assign done[1]      = (state == RESP) && (grant == PORT_B);

  // Per-port status flags, all cleared by that port's ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      revoked  <= 2'b00;
      badrel   <= 2'b00;
      lockwait <= 2'b00;
    end else begin
      revoked  <= (revoked | revoke_set) & ~done;
      badrel   <= badrel_eff & ~done;
      lockwait <= (lockwait | lockwait_set) & ~done;
    end
  end

  // Response data path: read data and whether the ack carries it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
      resp_rd <= 1'b0;
    end else begin
      if (state == RDWAIT) rdata_q <= mem_rdata;
      if (state == ACCESS)    resp_rd <= rw_q[grant];
      else if (state == IDLE) resp_rd <= 1'b0;
    end
  end

  // Outputs are forced quiet while reset is asserted, even mid-transaction.
  assign acc_en    = (state == ACCESS) && reset_n;
  assign rsp_en    = (state == RESP) && reset_n;
  assign mem_addr  = acc_en ? addr_q[grant] : '0;
  assign mem_we    = acc_en & ~rw_q[grant];
  assign mem_re    = acc_en & rw_q[grant];
  assign mem_wdata = mem_we ? wdata_q[grant] : '0;

  assign resp_err   = encode_err(revoked[grant], badrel[grant], lockwait[grant]);
  assign A_ack      = rsp_en && (grant == PORT_A);
  assign B_ack      = rsp_en && (grant == PORT_B);
  assign A_err      = A_ack ? resp_err : ERR_OK;
  assign B_err      = B_ack ? resp_err : ERR_OK;
  assign A_out_data = (A_ack && resp_rd) ? rdata_q : '0;
  assign B_out_data = (B_ack && resp_rd) ? rdata_q : '0;

endmodule

// File: tb/tb_csm_arbiter.sv
// Directed bench for csm_arbiter: a transaction-level expectation queue per
// port plus a reference memory, checked every cycle, with literal latency
// and status checks for the documented scenarios.
module tb_csm_arbiter;

  localparam int HOLD_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] A_in_AD, B_in_AD;
  logic       A_rw, A_enable, A_hold, A_release;
  logic       B_rw, B_enable, B_hold, B_release;
  logic       A_ack, B_ack;
  logic [7:0] A_out_data, B_out_data;
  logic [1:0] A_err, B_err;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re;

  csm_arbiter #(.DATA_W(8), .HOLD_TIMEOUT(HOLD_TIMEOUT), .RR_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .A_in_AD(A_in_AD), .A_rw(A_rw), .A_enable(A_enable), .A_hold(A_hold),
    .A_release(A_release), .A_ack(A_ack), .A_out_data(A_out_data), .A_err(A_err),
    .B_in_AD(B_in_AD), .B_rw(B_rw), .B_enable(B_enable), .B_hold(B_hold),
    .B_release(B_release), .B_ack(B_ack), .B_out_data(B_out_data), .B_err(B_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Storage array seen by the DUT.
  logic [7:0] sram [256];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  typedef struct { logic [1:0] err; logic rd; logic [7:0] data; } exp_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;

  exp_t       expq_a[$];
  exp_t       expq_b[$];
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] ref_mem [256];

  int         checks = 0;
  int         failures = 0;
  int         ack_cyc [2];
  logic [1:0] ack_err [2];
  logic [7:0] ack_data [2];
  int         we_cyc = -1;
  int         re_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input int p, input logic ack, input logic [1:0] err,
                            input logic [7:0] data);
    exp_t e;
    if (ack) begin
      ack_cyc[p]  = cyc;
      ack_err[p]  = err;
      ack_data[p] = data;
      if ((p == 0 && expq_a.size() == 0) || (p == 1 && expq_b.size() == 0)) begin
        chk($sformatf("unexpected_ack_%0d", p), ack, 1'b0);
      end else begin
        if (p == 0) e = expq_a.pop_front();
        else        e = expq_b.pop_front();
        chk($sformatf("ack_err_%0d", p), err, e.err);
        if (e.rd) chk($sformatf("ack_data_%0d", p), data, e.data);
      end
    end else begin
      chk($sformatf("idle_err_%0d", p), err, 2'b00);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the expectation queues.
  always @(negedge clk) begin
    wr_t w;
    logic [7:0] ra;
    check_port(0, A_ack, A_err, A_out_data);
    check_port(1, B_ack, B_err, B_out_data);
    chk("strobe_exclusive", mem_we & mem_re, 1'b0);
    if (mem_we) begin
      we_cyc = cyc;
      if (exp_wr.size() == 0) chk("unexpected_mem_we", mem_we, 1'b0);
      else begin
        w = exp_wr.pop_front();
        chk("mem_we_addr", mem_addr, w.addr);
        chk("mem_wdata", mem_wdata, w.data);
      end
    end
    if (mem_re) begin
      re_cyc = cyc;
      if (exp_rd.size() == 0) chk("unexpected_mem_re", mem_re, 1'b0);
      else begin
        ra = exp_rd.pop_front();
        chk("mem_re_addr", mem_addr, ra);
      end
    end
  end

  task automatic clear_all();
    A_in_AD = '0; A_rw = 0; A_enable = 0; A_hold = 0; A_release = 0;
    B_in_AD = '0; B_rw = 0; B_enable = 0; B_hold = 0; B_release = 0;
  endtask

  task automatic push_exp(input int p, input logic [1:0] err, input logic rd,
                          input logic [7:0] data);
    exp_t e;
    e.err = err; e.rd = rd; e.data = data;
    if (p == 0) expq_a.push_back(e);
    else        expq_b.push_back(e);
  endtask

  task automatic drive_start(input int p, input logic rw, input logic [7:0] addr,
                             input logic hold);
    if (p == 0) begin A_enable = 1; A_rw = rw; A_in_AD = addr; A_hold = hold; end
    else        begin B_enable = 1; B_rw = rw; B_in_AD = addr; B_hold = hold; end
  endtask

  // T0 of a transaction plus the model's expectation of its outcome.
  task automatic issue(input int p, input logic rw, input logic [7:0] addr,
                       input logic [7:0] data, input logic hold, input logic [1:0] err);
    wr_t w;
    drive_start(p, rw, addr, hold);
    push_exp(p, err, rw, rw ? ref_mem[addr] : 8'h00);
    if (rw) exp_rd.push_back(addr);
    else begin
      w.addr = addr; w.data = data;
      exp_wr.push_back(w);
      ref_mem[addr] = data;
    end
  endtask

  // T1: enable dropped early; write data presented on the AD bus.
  task automatic second(input int p, input logic rw, input logic [7:0] data);
    if (p == 0) begin A_enable = 0; A_hold = 0; A_rw = 0; A_in_AD = rw ? 8'h00 : data; end
    else        begin B_enable = 0; B_hold = 0; B_rw = 0; B_in_AD = rw ? 8'h00 : data; end
  endtask

  task automatic wait_ack(input int p, input int after, input int budget, input string name);
    int n = 0;
    while (ack_cyc[p] < after && n < budget) begin
      tick();
      n++;
    end
    if (ack_cyc[p] < after) chk(name, 32'(ack_cyc[p]), 32'(after));
  endtask

  task automatic single(input int p, input logic rw, input logic [7:0] addr,
                        input logic [7:0] data, input logic hold, input logic [1:0] err,
                        input int budget, output int c0);
    c0 = cyc;
    issue(p, rw, addr, data, hold, err);
    tick();
    second(p, rw, data);
    tick();
    clear_all();
    wait_ack(p, c0, budget, "single_ack_timeout");
  endtask

  task automatic contend(input logic [7:0] addr, output int la, output int lb);
    int c;
    c = cyc;
    issue(0, 1'b1, addr, 8'h00, 1'b0, 2'b00);
    issue(1, 1'b1, addr, 8'h00, 1'b0, 2'b00);
    tick();
    second(0, 1'b1, 8'h00);
    second(1, 1'b1, 8'h00);
    tick();
    clear_all();
    wait_ack(0, c, 40, "contend_a_timeout");
    wait_ack(1, c, 40, "contend_b_timeout");
    la = ack_cyc[0] - c;
    lb = ack_cyc[1] - c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, la, lb, crel;
    ack_cyc[0] = -1; ack_cyc[1] = -1;
    reset_n = 1'b0;
    clear_all();
    repeat (3) tick();
    chk("rst_A_ack", A_ack, 1'b0);
    chk("rst_B_ack", B_ack, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_A_out", A_out_data, 8'h00);
    chk("rst_B_err", B_err, 2'b00);
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: A write
    single(0, 1'b0, 8'h10, 8'h5A, 1'b0, 2'b00, 30, c0);
    chk("t1_we_lat", we_cyc - c0, 3);
    chk("t1_ack_lat", ack_cyc[0] - c0, 4);
    chk("t1_err", ack_err[0], 2'b00);
    tick();

    // 2: A read back
    single(0, 1'b1, 8'h10, 8'h00, 1'b0, 2'b00, 30, c0);
    chk("t2_re_lat", re_cyc - c0, 2);
    chk("t2_ack_lat", ack_cyc[0] - c0, 4);
    chk("t2_data", ack_data[0], 8'h5A);
    tick();

    // 3: simultaneous requests, pointer alternates
    contend(8'h10, la, lb);
    chk("t3a_lat_A", la, 4);
    chk("t3a_lat_B", lb, 8);
    chk("t3a_data_B", ack_data[1], 8'h5A);
    tick();
    contend(8'h10, la, lb);
    chk("t3b_lat_B", lb, 4);
    chk("t3b_lat_A", la, 8);
    tick();

    // 4: A holds the lock and goes idle; B starves until revocation
    single(0, 1'b1, 8'h10, 8'h00, 1'b1, 2'b00, 30, c0);
    chk("t4_hold_lat", ack_cyc[0] - c0, 4);
    tick();
    single(1, 1'b0, 8'h40, 8'h77, 1'b0, 2'b01, 60, c0);
    chk("t4_B_lat", ack_cyc[1] - c0, 2 + HOLD_TIMEOUT + 2);
    chk("t4_B_err", ack_err[1], 2'b01);
    tick();
    single(0, 1'b0, 8'h50, 8'h33, 1'b0, 2'b10, 30, c0);
    chk("t4_A_lat", ack_cyc[0] - c0, 4);
    chk("t4_A_err", ack_err[0], 2'b10);
    tick();

    // 5a: stray release from idle B
    c0 = cyc;
    B_release = 1'b1;
    push_exp(1, 2'b11, 1'b0, 8'h00);
    tick();
    B_release = 1'b0;
    wait_ack(1, c0, 10, "t5_badrel_timeout");
    chk("t5_badrel_lat", ack_cyc[1] - c0, 2);
    chk("t5_badrel_err", ack_err[1], 2'b11);
    tick();

    // 5b: owner release frees the lock without an ack
    single(0, 1'b0, 8'h60, 8'h44, 1'b1, 2'b00, 30, c0);
    tick();
    crel = cyc;
    A_release = 1'b1;
    tick();
    A_release = 1'b0;
    repeat (3) tick();
    chk("t5_no_release_ack", ack_cyc[0] >= crel, 1'b0);
    single(1, 1'b1, 8'h60, 8'h00, 1'b0, 2'b00, 40, c0);
    chk("t5_B_lat", ack_cyc[1] - c0, 4);
    chk("t5_B_data", ack_data[1], 8'h44);
    tick();

    // 6: contention leaves pointer on B, then reset mid-read restores it
    contend(8'h60, la, lb);
    chk("t6a_lat_A", la, 4);
    chk("t6a_lat_B", lb, 8);
    tick();
    c0 = cyc;
    drive_start(0, 1'b1, 8'h10, 1'b0);
    exp_rd.push_back(8'h10);
    tick();
    second(0, 1'b1, 8'h00);
    tick();
    clear_all();
    tick();
    reset_n = 1'b0;
    chk("t6_rst_ack", A_ack, 1'b0);
    tick();
    chk("t6_rst_mem_re", mem_re, 1'b0);
    chk("t6_rst_mem_addr", mem_addr, 8'h00);
    chk("t6_rst_A_out", A_out_data, 8'h00);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("t6_no_ack_after_reset", ack_cyc[0] >= c0, 1'b0);
    contend(8'h10, la, lb);
    chk("t6b_lat_A", la, 4);
    chk("t6b_lat_B", lb, 8);

    repeat (4) tick();
    chk("expq_a_drained", expq_a.size(), 0);
    chk("expq_b_drained", expq_b.size(), 0);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
